// File: rtl/int_ctrl.sv
// Interrupt controller: 16 level/edge sources with polarity, enable and routing onto 6 CPU lines.
// irq_src to int_out takes 3 posedges, or 4 when INTC_SYNC_EN adds a second synchroniser flop.
// Register accesses always complete in one cycle, so there is no backpressure.
module int_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] irq_src,
    input  logic        conf_en,
    input  logic [3:0]  conf_wen,
    input  logic [7:0]  conf_addr,
    input  logic [31:0] conf_wdata,
    output logic [31:0] conf_rdata,
    output logic [5:0]  int_out
);

    logic [15:0] s;
`ifdef INTC_SYNC_EN
    logic [15:0] sync_q;
`endif
    logic [15:0] act;
    logic [15:0] act_d;
    logic [15:0] rise;
    logic [15:0] edge_sel;
    logic [15:0] pol;
    logic [15:0] enable;
    logic [15:0] pending;
    logic [23:0] route_lo;
    logic [23:0] route_hi;

    logic [5:0]  idx;
    logic        wr_acc;
    logic        rd_acc;
    logic [23:0] wmask;
    logic [15:0] wr16;
    logic [23:0] wr24;
    logic [15:0] clr_bits;
    logic [15:0] pend_nxt;
    logic [47:0] route_all;
    logic [5:0]  int_nxt;
    logic [31:0] rd_mux;

    // Word-aligned address: the low two bits and the top write byte have no storage behind them.
    logic unused_bits;
    assign unused_bits = &{1'b0, conf_addr[1:0], conf_wdata[31:24]};

    always_comb begin
        idx      = conf_addr[7:2];
        wr_acc   = conf_en && (conf_wen != 4'b0000);
        rd_acc   = conf_en && (conf_wen == 4'b0000);
        wmask    = {{8{conf_wen[2]}}, {8{conf_wen[1]}}, {8{conf_wen[0]}}};
        wr16     = conf_wdata[15:0] & wmask[15:0];
        wr24     = conf_wdata[23:0] & wmask;
        clr_bits = (wr_acc && idx == 6'd5) ? wr16 : 16'h0000;

        act  = s ^ pol;
        rise = act & ~act_d;
        // Edge sources: a same-cycle set beats the clear.
        pend_nxt = (edge_sel & (rise | (pending & ~clr_bits))) | (~edge_sel & act);

        route_all = {route_hi, route_lo};
        int_nxt   = 6'b000000;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 16; i++) begin
                if (pending[i] && enable[i] && route_all[3*i +: 3] == 3'(k))
                    int_nxt[k] = 1'b1;
            end
        end

        rd_mux = 32'h0000_0000;
        case (idx)
            6'd0:    rd_mux = {16'h0000, s};
            6'd1:    rd_mux = {16'h0000, edge_sel};
            6'd2:    rd_mux = {16'h0000, pol};
            6'd3:    rd_mux = {16'h0000, enable};
            6'd4:    rd_mux = {16'h0000, pending};
            6'd6:    rd_mux = {8'h00, route_lo};
            6'd7:    rd_mux = {8'h00, route_hi};
            default: rd_mux = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef INTC_SYNC_EN
            sync_q     <= '0;
`endif
            s          <= '0;
            act_d      <= '0;
            pending    <= '0;
            int_out    <= '0;
            edge_sel   <= '0;
            pol        <= '0;
            enable     <= '0;
            route_lo   <= '0;
            route_hi   <= '0;
            conf_rdata <= '0;
        end else begin
`ifdef INTC_SYNC_EN
            sync_q <= irq_src;
            s      <= sync_q;
`else
            s      <= irq_src;
`endif
            act_d   <= act;
            pending <= pend_nxt;
            int_out <= int_nxt;

            if (wr_acc) begin
                case (idx)
                    6'd1: edge_sel <= (edge_sel & ~wmask[15:0]) | wr16;
                    6'd2: pol      <= (pol & ~wmask[15:0]) | wr16;
                    6'd3: enable   <= (enable & ~wmask[15:0]) | wr16;
                    6'd6: route_lo <= (route_lo & ~wmask) | wr24;
                    6'd7: route_hi <= (route_hi & ~wmask) | wr24;
                    default: ;
                endcase
            end

            if (rd_acc)
                conf_rdata <= rd_mux;
        end
    end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state updates on posedge clk.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 irq_src  input  16  asynchronous device interrupt requests, one bit per source.
REQ-004 conf_en  input  1  register access strobe, one access per cycle.
REQ-005 conf_wen  input  4  byte write enables; 0 = read.
REQ-006 conf_addr  input  8  byte address, word aligned; bits[1:0] ignored.
REQ-007 conf_wdata  input  32  write data.
REQ-008 conf_rdata  output  32  read data, registered.
REQ-009 int_out  output  6  registered hardware interrupt lines, drive CPU Cause.IP[7:2] (int_out[0] -> IP2).

Function
REQ-010 Register map: 0x00 RAW (RO, synchronised irq_src); 0x04 EDGE (1 = edge, 0 = level); 0x08 POL (1 = active-low/falling); 0x0C ENABLE; 0x10 PENDING (RO); 0x14 CLEAR (W1C, reads 0); 0x18 ROUTE_LO; 0x1C ROUTE_HI.
REQ-011 Bits [15:0] of RAW/EDGE/POL/ENABLE/PENDING/CLEAR are used; bits [31:16] read 0 and ignore writes.
REQ-012 ROUTE_LO holds a 3-bit line number for source i (0..7) at bits [3i+2:3i]; ROUTE_HI holds sources 8..15 the same way; bits [31:24] read 0.
REQ-013 A route value of 0..5 selects int_out[value]; a value of 6 or 7 routes the source nowhere.
REQ-014 Writes apply on the posedge where conf_en=1, byte-wise per conf_wen; unmapped addresses ignore writes.
REQ-015 A read (conf_en=1, conf_wen=0) presents conf_rdata on the following cycle; conf_rdata holds its value when no read occurs; unmapped addresses return 0.
REQ-016 The synchroniser output is s; act[i] = s[i] XOR POL[i]; act_d is act registered one cycle.
REQ-017 Level source: PENDING[i] is registered act[i] each cycle; CLEAR has no effect on it.
REQ-018 Edge source: PENDING[i] is set on the cycle where act[i]=1 and act_d[i]=0, and cleared by a CLEAR write with bit i=1.
REQ-019 When set and clear occur in the same cycle, set wins.
REQ-020 A POL or EDGE write that produces an act 0->1 transition is a valid edge; no masking is applied.
REQ-021 PENDING is captured regardless of ENABLE; a pending source raises its line as soon as it is enabled.
REQ-022 int_out[k] is registered each cycle as the OR over i of (PENDING[i] AND ENABLE[i] AND route(i)==k).
REQ-023 Latency with INTC_SYNC_EN defined: an irq_src level change to an int_out change takes exactly 4 posedges (sync, sync, PENDING, int_out).
REQ-024 A CLEAR write takes effect on int_out on the second posedge after the write.
REQ-025 A RAW read returns s as it stood at the access posedge.

Reset
REQ-026 While reset=1 at a posedge, the following clear to 0: all registers, PENDING, act_d, synchroniser flops, int_out and conf_rdata.
REQ-027 Reset overrides any simultaneous register access.
REQ-028 On reset release all sources read as level/active-high/disabled/route 0, and no edge is seen on the first cycle.

Configuration
REQ-029 Macro INTC_SYNC_EN defined: irq_src passes through a two-flop synchroniser before s.
REQ-030 Macro INTC_SYNC_EN undefined: irq_src passes through one flop only, and the REQ-023 latency becomes 3 posedges; all other behaviour is identical.

Verification
REQ-031 Level path: EDGE=0, POL=0, ENABLE=0x0001, ROUTE_LO=0; raise irq_src[0] -> int_out=6'b000001 exactly 4 cycles later; drop it -> int_out=0 4 cycles later.
REQ-032 Edge and clear: EDGE=0x0100, ENABLE=0x0100, ROUTE_HI[2:0]=5; pulse irq_src[8] for 3 cycles -> int_out[5]=1 and stays 1; write CLEAR=0x0100 -> int_out[5]=0 two cycles later; PENDING reads 0.
REQ-033 Set-beats-clear: for an edge source, time a CLEAR write to the same cycle as the edge -> PENDING bit stays 1.
REQ-034 Routing and masking: sources 3 and 4 routed to line 2, source 5 routed to 7, all pending -> int_out=6'b000100; ENABLE bit 3 cleared -> int_out still 6'b000100; ENABLE bit 4 cleared -> int_out=0.
REQ-035 Polarity: POL=0x0002, EDGE=0, irq_src[1]=0, ENABLE=0x0002 -> PENDING=0x0002 and int_out[0]=1; a read of 0x40 returns 0 on the next cycle.
REQ-036 Reset mid-operation: with lines asserted, pulse reset for one cycle -> all outputs 0 next cycle; a read of ENABLE returns 0.
